// File: rtl/blocking_out_producer.sv
// blocking_out_producer
// Accumulating producer on a blocking output. Each offer is m_in plus the
// running accumulator. The offer is held until the consumer accepts it, and
// the accepted value then becomes the new accumulator.
// Optional feature: define BLOCKING_OUT_PRODUCER_TIMEOUT_EN to abandon offers
// that stay unaccepted for TIMEOUT cycles.
module blocking_out_producer #(
    parameter logic signed [31:0] INIT_VAR = 32'sd1337,
    parameter int                 TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] m_in,
    input  logic               b_out_sync,
    output logic signed [31:0] b_out,
    output logic               b_out_notify,
    output logic [7:0]         sent_cnt,
    output logic               timeout_flag
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic signed [31:0] b_out_q, b_out_d;
    logic               notify_q, notify_d;
    logic signed [31:0] var_signal_q, var_signal_d;
    logic [7:0]         sent_cnt_q, sent_cnt_d;

    // TIMEOUT is only meaningful in 2..65535, so reject anything else at elaboration
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("blocking_out_producer: TIMEOUT must be in 2..65535");
    end

`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_flag_q, timeout_flag_d;
`endif

    // Next-state logic: build an offer in IDLE, then wait in SEND for acceptance
    always_comb begin
        state_d      = state_q;
        b_out_d      = b_out_q;
        notify_d     = notify_q;
        var_signal_d = var_signal_q;
        sent_cnt_d   = sent_cnt_q;
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        timeout_flag_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                b_out_d  = m_in + var_signal_q;
                notify_d = 1'b1;
                state_d  = SEND;
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
                tmo_cnt_d = 16'd0;
`endif
            end
            SEND: begin
                if (b_out_sync) begin
                    var_signal_d = b_out_q;
                    sent_cnt_d   = sent_cnt_q + 8'd1;
                    notify_d     = 1'b0;
                    state_d      = IDLE;
                end
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
                else if (tmo_cnt_q == TimeoutLast) begin
                    notify_d       = 1'b0;
                    timeout_flag_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                notify_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset also withdraws any live offer
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            b_out_q      <= 32'sd0;
            notify_q     <= 1'b0;
            var_signal_q <= INIT_VAR;
            sent_cnt_q   <= 8'd0;
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
            tmo_cnt_q      <= 16'd0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            b_out_q      <= b_out_d;
            notify_q     <= notify_d;
            var_signal_q <= var_signal_d;
            sent_cnt_q   <= sent_cnt_d;
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            timeout_flag_q <= timeout_flag_d;
`endif
        end
    end

    assign b_out        = b_out_q;
    assign b_out_notify = notify_q;
    assign sent_cnt     = sent_cnt_q;
`ifdef BLOCKING_OUT_PRODUCER_TIMEOUT_EN
    assign timeout_flag = timeout_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_blocking_out_producer.sv
// Testbench for blocking_out_producer in its default build (timeout feature off).
module tb_blocking_out_producer;

   localparam logic signed [31:0] InitVar = 32'sd1337;

   logic               clk;
   logic               rst;
   logic signed [31:0] m_in;
   logic               b_out_sync;
   logic signed [31:0] b_out;
   logic               b_out_notify;
   logic [7:0]         sent_cnt;
   logic               timeout_flag;

   int totalChecks = 0;
   int passChecks  = 0;

   logic               expOffering;
   logic signed [31:0] expBOut;
   logic signed [31:0] expAccum;
   logic [7:0]         expSent;

   blocking_out_producer #(
      .INIT_VAR (InitVar),
      .TIMEOUT  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m_in         (m_in),
      .b_out_sync   (b_out_sync),
      .b_out        (b_out),
      .b_out_notify (b_out_notify),
      .sent_cnt     (sent_cnt),
      .timeout_flag (timeout_flag)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports a FAIL line when the values differ
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      else
         passChecks++;
   endtask

   // Drive one cycle of inputs, then wait to the following falling edge so outputs are settled
   task automatic applyStimulus(input logic rstV, input logic signed [31:0] mV, input logic syncV);
      rst        = rstV;
      m_in       = mV;
      b_out_sync = syncV;
      @(negedge clk);
   endtask

   // Transaction-level reference: either an offer is outstanding or not; accepted offers
   // become the accumulator and bump the transfer count. Checked every cycle just after the edge.
   always begin
      @(posedge clk);
      if (!rst) begin
         expOffering = 1'b0;
         expBOut     = 32'sd0;
         expAccum    = InitVar;
         expSent     = 8'd0;
      end else if (!expOffering) begin
         expBOut     = m_in + expAccum;
         expOffering = 1'b1;
      end else if (b_out_sync) begin
         expAccum    = expBOut;
         expSent     = expSent + 8'd1;
         expOffering = 1'b0;
      end
      #1;
      checkOutput("model b_out", b_out, expBOut);
      checkOutput("model b_out_notify", 32'(b_out_notify), 32'(expOffering));
      checkOutput("model sent_cnt", 32'(sent_cnt), 32'(expSent));
      checkOutput("model timeout_flag", 32'(timeout_flag), 32'd0);
   end

   // Directed scenarios with hand-computed literals, then a long randomized run
   initial begin
      rst        = 1'b0;
      m_in       = 32'sd0;
      b_out_sync = 1'b0;

      applyStimulus(1'b0, 32'sd0, 1'b0);
      applyStimulus(1'b0, 32'sd0, 1'b0);
      checkOutput("reset b_out", b_out, 32'd0);
      checkOutput("reset notify", 32'(b_out_notify), 32'd0);
      checkOutput("reset sent_cnt", 32'(sent_cnt), 32'd0);
      checkOutput("reset timeout_flag", 32'(timeout_flag), 32'd0);

      applyStimulus(1'b1, 32'sd5, 1'b1);
      checkOutput("first offer value", b_out, 32'd1342);
      checkOutput("first offer notify", 32'(b_out_notify), 32'd1);
      applyStimulus(1'b1, 32'sd5, 1'b1);
      checkOutput("after transfer notify", 32'(b_out_notify), 32'd0);
      checkOutput("after transfer sent_cnt", 32'(sent_cnt), 32'd1);
      checkOutput("idle holds b_out", b_out, 32'd1342);
      applyStimulus(1'b1, 32'sd5, 1'b1);
      checkOutput("second offer value", b_out, 32'd1347);
      applyStimulus(1'b1, 32'sd5, 1'b1);
      checkOutput("second transfer sent_cnt", 32'(sent_cnt), 32'd2);

      applyStimulus(1'b0, 32'sd0, 1'b0);
      applyStimulus(1'b1, 32'sh7FFFFFFF, 1'b0);
      checkOutput("wrap offer value", b_out, 32'h80000538);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, $signed($urandom), 1'b0);
         checkOutput("stall b_out stable", b_out, 32'h80000538);
         checkOutput("stall notify stable", 32'(b_out_notify), 32'd1);
      end
      applyStimulus(1'b1, 32'sd0, 1'b1);
      checkOutput("stall then transfer sent_cnt", 32'(sent_cnt), 32'd1);
      checkOutput("stall then transfer notify", 32'(b_out_notify), 32'd0);

      applyStimulus(1'b1, 32'sd3, 1'b0);
      checkOutput("offer before reset", 32'(b_out_notify), 32'd1);
      applyStimulus(1'b0, 32'sd3, 1'b1);
      checkOutput("reset in SEND notify", 32'(b_out_notify), 32'd0);
      checkOutput("reset in SEND sent_cnt", 32'(sent_cnt), 32'd0);

      for (int i = 0; i < 510; i++)
         applyStimulus(1'b1, $signed($urandom), 1'b1);
      checkOutput("255 transfers sent_cnt", 32'(sent_cnt), 32'd255);
      applyStimulus(1'b1, $signed($urandom), 1'b1);
      applyStimulus(1'b1, $signed($urandom), 1'b1);
      checkOutput("256 transfers wrap sent_cnt", 32'(sent_cnt), 32'd0);

      for (int i = 0; i < 2000; i++)
         applyStimulus(($urandom_range(0, 49) != 0), $signed($urandom), 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule
